// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Sequential instruction fetcher with a DEPTH-entry prefetch
//             queue of {pc, word} pairs and a single-cycle redirect flush.
//
//  Parameters
//    DEPTH     prefetch queue entries (power of two, 2..16)
//    RESET_PC  first fetch byte address after reset (word aligned)
//
//  Ports
//    clk             in   clock, rising edge
//    rst_n           in   asynchronous active-low reset
//    imem_addr       out  [31:0] byte address to instruction memory
//    imem_rdata      in   [31:0] instruction word for imem_addr (same cycle)
//    redirect_valid  in   branch/jump redirect request
//    redirect_pc     in   [31:0] redirect target byte address
//    instr_valid     out  queue head holds a valid instruction
//    instr_ready     in   consumer accepts the head this cycle
//    instr           out  [31:0] head instruction word
//    instr_pc        out  [31:0] byte address of head instruction
//    misalign_err    out  sticky misaligned-redirect flag (only when the
//                         FETCH_MISALIGN_CHECK_EN macro is defined)
//
//  Build option: define FETCH_MISALIGN_CHECK_EN to add misalign_err.
//
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    // Only the word address is stored, so the two low address bits are
    // structurally zero and the 30-bit increment wraps FFFF_FFFC -> 0.
    logic [29:0]        r_pc_word;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;

    logic [29:0]        r_q_pc   [DEPTH];
    logic [31:0]        r_q_word [DEPTH];

    logic               w_push;
    logic               w_pop;

    assign imem_addr   = {r_pc_word, 2'b00};

    // Redirect masks the head for the cycle: the queue is being flushed.
    assign instr_valid = (r_count != '0) && !redirect_valid;
    assign instr       = r_q_word[r_rptr];
    assign instr_pc    = {r_q_pc[r_rptr], 2'b00};

    assign w_pop  = instr_valid && instr_ready;
    // A full queue still accepts a word when the head leaves the same cycle;
    // the write lands in the slot being vacated.
    assign w_push = !redirect_valid && ((r_count != c_depth_cnt) || w_pop);

    // ------------------------------------------------------------------
    // Control state: fetch pointer, queue pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_word <= RESET_PC[31:2];
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else if (redirect_valid) begin
            r_pc_word <= redirect_pc[31:2];
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_pc_word <= r_pc_word + 30'd1;
                r_wptr    <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage: contents are don't-care after reset, so no reset here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]   <= r_pc_word;
            r_q_word[r_wptr] <= imem_rdata;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    // Low target bits are dropped silently in this build.
    logic w_unused_redirect_lsbs;
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Scoreboard bench for instr_fetch_unit (DEPTH=4, RESET_PC=0).
//             Memory model: word at byte address A is 32'h1000_0000 + A/4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int passed = 0;
    int total  = 0;

    // expected consumed entries: {pc, word}
    logic [63:0] exp_q[$];

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    assign imem_rdata = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed expected pc with its hand-known memory word.
    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pop: got pc %h expected no output", instr_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("pop_pc", instr_pc, e[63:32]);
                check("pop_instr", instr, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // ---- reset state
        #2;
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0000_0000);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
`endif

        // ---- streaming from reset, one instruction per cycle
        expect_fetch(32'h00, 32'h1000_0000);
        expect_fetch(32'h04, 32'h1000_0001);
        expect_fetch(32'h08, 32'h1000_0002);
        expect_fetch(32'h0C, 32'h1000_0003);
        expect_fetch(32'h10, 32'h1000_0004);
        expect_fetch(32'h14, 32'h1000_0005);
        expect_fetch(32'h18, 32'h1000_0006);
        expect_fetch(32'h1C, 32'h1000_0007);
        instr_ready = 1'b1;
        #10 rst_n = 1'b1;
        step(1);
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        check("first_pc", instr_pc, 32'h0);
        step(8);
        instr_ready = 1'b0;

        // ---- stall until full, then drain with no gap
        rst_n = 1'b0;
        #1;
        check("rst2_valid", {31'b0, instr_valid}, 32'd0);
        #5 rst_n = 1'b1;
        step(10);
        check("full_imem_addr", imem_addr, 32'h10);
        check("full_valid", {31'b0, instr_valid}, 32'd1);
        check("full_head_pc", instr_pc, 32'h0);
        expect_fetch(32'h00, 32'h1000_0000);
        expect_fetch(32'h04, 32'h1000_0001);
        expect_fetch(32'h08, 32'h1000_0002);
        expect_fetch(32'h0C, 32'h1000_0003);
        expect_fetch(32'h10, 32'h1000_0004);
        expect_fetch(32'h14, 32'h1000_0005);
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("drain_valid", {31'b0, instr_valid}, 32'd1);
            check("drain_pc", instr_pc, 32'(k * 4));
            step(1);
        end

        // ---- redirect while full and ready
        expect_fetch(32'h200, 32'h1000_0080);
        expect_fetch(32'h204, 32'h1000_0081);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("redir_valid_low", {31'b0, instr_valid}, 32'd0);
        step(1);
        redirect_valid = 1'b0;
        check("redir_imem_addr", imem_addr, 32'h200);
        check("redir_n1_valid", {31'b0, instr_valid}, 32'd0);
        step(1);
        check("redir_n2_valid", {31'b0, instr_valid}, 32'd1);
        check("redir_n2_pc", instr_pc, 32'h200);
        step(2);
        instr_ready = 1'b0;

        // ---- back-to-back redirects, misaligned last target, pc wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step(1);
        redirect_pc    = 32'hFFFF_FFFA;
        step(1);
        redirect_valid = 1'b0;
        check("wrap_imem_addr", imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_set", {31'b0, misalign_err}, 32'd1);
`endif
        expect_fetch(32'hFFFF_FFF8, 32'h4FFF_FFFE);
        expect_fetch(32'hFFFF_FFFC, 32'h4FFF_FFFF);
        expect_fetch(32'h0000_0000, 32'h1000_0000);
        expect_fetch(32'h0000_0004, 32'h1000_0001);
        instr_ready = 1'b1;
        step(5);
        instr_ready = 1'b0;
        step(2);
        check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        check("pre_rst_pc", instr_pc, 32'h8);

        // ---- reset mid-stream with three entries queued
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_rst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mid_rst_misalign", {31'b0, misalign_err}, 32'd0);
`endif
        expect_fetch(32'h00, 32'h1000_0000);
        expect_fetch(32'h04, 32'h1000_0001);
        expect_fetch(32'h08, 32'h1000_0002);
        #5;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        step(1);
        check("restart_valid", {31'b0, instr_valid}, 32'd1);
        check("restart_pc", instr_pc, 32'h0);
        step(3);
        instr_ready = 1'b0;
        step(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
